// File: rtl/wb_collect_64_pkg.sv
// wb_collect_64_pkg: shared widths, default sizing and the writeback entry type
package wb_collect_64_pkg;
    localparam int TAG_W     = 5;
    localparam int DATA_W    = 64;
    localparam int DEPTH_DEF = 8;
    localparam int LAT_DEF   = 7;
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: result FIFO storage, wrapping pointers and occupancy count
// ports: clk, rst (sync, active-high), push/din write side, pop read side,
//        head (current oldest entry, zero when empty), count, full
module wb_fifo
    import wb_collect_64_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   din,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    entry_t mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    assign full = count == (AW+1)'(DEPTH);
    // head reads as zero when empty so the writeback bus is clean after reset
    assign head = count != '0 ? mem[rptr] : '0;
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/wb_collect_64.sv
// wb_collect_64: collects execution-unit results into a FIFO and issues credits
// ports: clk, rst (sync, active-high), issue_fire/issue_ok credit handshake,
//        res_valid/res_tag/res_data from the execution unit,
//        wb_valid/wb_ready/wb_tag/wb_data to the register file,
//        err (sticky illegal-event flag) only when WB_COLLECT_ERR_EN is defined
module wb_collect_64
    import wb_collect_64_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_fire,
    output logic              issue_ok,
    input  logic              res_valid,
    input  logic [TAG_W-1:0]  res_tag,
    input  logic [DATA_W-1:0] res_data,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_data
`ifdef WB_COLLECT_ERR_EN
    ,
    output logic              err
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || LAT < 1) begin : g_bad_param
        $error("wb_collect_64: DEPTH must be a power of two in 2..16 and LAT >= 1");
    end
    logic [CW-1:0] fifo_count, inflight;
    logic          full, push, pop;
    entry_t        head;
    assign wb_valid = fifo_count != '0;
    assign pop      = wb_valid && wb_ready;
    // a pop frees the slot the push lands in, so push is allowed even when full
    assign push     = res_valid && (!full || pop);
    assign issue_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
    assign wb_tag   = head.tag;
    assign wb_data  = head.data;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({res_tag, res_data}),
        .head  (head),
        .count (fifo_count),
        .full  (full)
    );
    always_ff @(posedge clk) begin
        if (rst) inflight <= '0;
        else if (issue_fire && !res_valid && inflight != CW'(DEPTH)) inflight <= inflight + CW'(1);
        else if (res_valid && !issue_fire && inflight != '0) inflight <= inflight - CW'(1);
    end
`ifdef WB_COLLECT_ERR_EN
    logic illegal;
    assign illegal = (res_valid && full && !pop) ||
                     (issue_fire && !res_valid && inflight == CW'(DEPTH)) ||
                     (res_valid && !issue_fire && inflight == '0);
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if (illegal) err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_wb_collect_64.sv
// tb_wb_collect_64: randomized self-checking bench with a queue-based reference model
module tb_wb_collect_64;
    localparam int DEPTH = 8;
    localparam int LAT   = 7;
    logic        clk = 1'b0;
    logic        rst, issue_fire, issue_ok, res_valid, wb_valid, wb_ready;
    logic [4:0]  res_tag, wb_tag;
    logic [63:0] res_data, wb_data;
`ifdef WB_COLLECT_ERR_EN
    logic        err;
`endif
    int total = 0;
    int bad   = 0;
    logic [68:0] q[$];
    int  m_infl;
    bit  m_err;
    typedef struct { int due; logic [4:0] t; logic [63:0] d; } op_t;
    op_t pend[$];

    always #5 clk = ~clk;

    wb_collect_64 #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .issue_fire(issue_fire), .issue_ok(issue_ok),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data)
`ifdef WB_COLLECT_ERR_EN
        , .err(err)
`endif
    );

    task automatic tick();
        bit pop, push;
        pop  = (q.size() != 0) && wb_ready;
        push = res_valid && (q.size() < DEPTH || pop);
        if (rst) begin
            q.delete();
            m_infl = 0;
            m_err  = 0;
        end else begin
            if (res_valid && !push) m_err = 1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back({res_tag, res_data});
            if (issue_fire && !res_valid) begin
                if (m_infl == DEPTH) m_err = 1; else m_infl++;
            end else if (res_valid && !issue_fire) begin
                if (m_infl == 0) m_err = 1; else m_infl--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; issue_fire = 0; res_valid = 0; res_tag = '0; res_data = '0;
    endtask

    task automatic do_reset();
        idle(); wb_ready = 0; rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            issue_fire = 1; tick();
        end
        issue_fire = 0;
    endtask

    task automatic deliver(input logic [4:0] t, input logic [63:0] d);
        res_valid = 1; res_tag = t; res_data = d;
        tick();
        res_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0b want=0", wb_valid); end
        total++; if (wb_tag !== 5'd0) begin bad++; $display("FAIL reset_wb_tag got=%0h want=0", wb_tag); end
        total++; if (wb_data !== 64'd0) begin bad++; $display("FAIL reset_wb_data got=%0h want=0", wb_data); end
        total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL reset_issue_ok got=%0b want=1", issue_ok); end
`ifdef WB_COLLECT_ERR_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
`endif
    endtask

    task automatic test_single();
        do_reset();
        wb_ready = 1;
        issue_n(1);
        for (int i = 0; i < LAT - 1; i++) begin
            total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL single_ok_wait got=%0b want=1", issue_ok); end
            tick();
        end
        deliver(5'd3, 64'hEEEEEEEEEEEEEEEE);
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", wb_valid); end
        total++; if (wb_tag !== 5'd3) begin bad++; $display("FAIL single_tag got=%0h want=3", wb_tag); end
        total++; if (wb_data !== 64'hEEEEEEEEEEEEEEEE) begin bad++; $display("FAIL single_data got=%0h want=eeeeeeeeeeeeeeee", wb_data); end
        total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL single_ok got=%0b want=1", issue_ok); end
        tick();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%0b want=0", wb_valid); end
    endtask

    task automatic test_fill();
        int accepted = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            total++; if (issue_ok !== ((q.size() + m_infl) < DEPTH)) begin bad++; $display("FAIL fill_ok got=%0b want=%0b", issue_ok, (q.size() + m_infl) < DEPTH); end
            issue_fire = issue_ok;
            if (issue_ok) accepted++;
            tick();
        end
        issue_fire = 0;
        total++; if (accepted != DEPTH) begin bad++; $display("FAIL fill_accepted got=%0d want=%0d", accepted, DEPTH); end
        total++; if (issue_ok !== 1'b0) begin bad++; $display("FAIL fill_ok_low got=%0b want=0", issue_ok); end
        repeat (LAT) tick();
        for (int i = 0; i < DEPTH; i++) deliver(5'(i), {$urandom, $urandom});
        total++; if (dut.fifo_count !== 4'(DEPTH)) begin bad++; $display("FAIL fill_count got=%0d want=%0d", dut.fifo_count, DEPTH); end
        total++; if (issue_ok !== 1'b0) begin bad++; $display("FAIL fill_ok_full got=%0b want=0", issue_ok); end
        wb_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (wb_valid !== 1'b1 || wb_tag !== 5'(i) || wb_data !== q[0][63:0]) begin bad++; $display("FAIL fill_drain got=%0b/%0h/%0h want=1/%0h/%0h", wb_valid, wb_tag, wb_data, i, q[0][63:0]); end
            tick();
            if (i == 0) begin
                total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL fill_ok_return got=%0b want=1", issue_ok); end
            end
        end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL fill_empty got=%0b want=0", wb_valid); end
        wb_ready = 0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        issue_n(DEPTH);
        for (int i = 0; i < DEPTH; i++) deliver(5'(10 + i), {$urandom, $urandom});
        issue_n(1);
        total++; if (issue_ok !== 1'b0) begin bad++; $display("FAIL full_ok got=%0b want=0", issue_ok); end
        wb_ready = 1;
        deliver(5'd31, {$urandom, $urandom});
        wb_ready = 0;
        total++; if (dut.fifo_count !== 4'(DEPTH) || q.size() != DEPTH) begin bad++; $display("FAIL full_count got=%0d want=%0d", dut.fifo_count, DEPTH); end
        total++; if (wb_tag !== 5'd11) begin bad++; $display("FAIL full_head got=%0h want=b", wb_tag); end
        wb_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (wb_valid !== 1'b1 || {wb_tag, wb_data} !== q[0]) begin bad++; $display("FAIL full_drain got=%0h/%0h want=%0h", wb_tag, wb_data, q[0]); end
            tick();
        end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%0b want=0", wb_valid); end
`ifdef WB_COLLECT_ERR_EN
        total++; if (err !== m_err) begin bad++; $display("FAIL full_err got=%0b want=%0b", err, m_err); end
`endif
        wb_ready = 0;
    endtask

    task automatic test_orphan();
        logic [68:0] first;
        do_reset();
        issue_n(1);
        deliver(5'd7, {$urandom, $urandom});
        first = q[0];
        deliver(5'd20, {$urandom, $urandom});
        total++; if (dut.inflight !== 4'd0) begin bad++; $display("FAIL orphan_inflight got=%0d want=0", dut.inflight); end
        total++; if ({wb_tag, wb_data} !== first) begin bad++; $display("FAIL orphan_head got=%0h/%0h want=%0h", wb_tag, wb_data, first); end
        total++; if (dut.fifo_count !== 4'(q.size())) begin bad++; $display("FAIL orphan_count got=%0d want=%0d", dut.fifo_count, q.size()); end
`ifdef WB_COLLECT_ERR_EN
        total++; if (err !== 1'b1) begin bad++; $display("FAIL orphan_err got=%0b want=1", err); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_n(DEPTH);
        for (int i = 0; i < 5; i++) deliver(5'(i), {$urandom, $urandom});
        total++; if (dut.fifo_count !== 4'd5 || dut.inflight !== 4'd3) begin bad++; $display("FAIL mid_state got=%0d/%0d want=5/3", dut.fifo_count, dut.inflight); end
        rst = 1; issue_fire = 1; res_valid = 1; wb_ready = 1;
        tick();
        idle(); wb_ready = 0;
        total++; if (wb_valid !== 1'b0 || wb_tag !== 5'd0 || wb_data !== 64'd0) begin bad++; $display("FAIL mid_wb got=%0b/%0h/%0h want=0/0/0", wb_valid, wb_tag, wb_data); end
        total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL mid_ok got=%0b want=1", issue_ok); end
        total++; if (dut.inflight !== 4'd0) begin bad++; $display("FAIL mid_inflight got=%0d want=0", dut.inflight); end
`ifdef WB_COLLECT_ERR_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err got=%0b want=0", err); end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        wb_ready = 1;
        issue_n(3);
        for (int i = 0; i < 20; i++) begin
            issue_fire = 1; res_valid = 1;
            res_tag = 5'($urandom); res_data = {$urandom, $urandom};
            tick();
            total++; if (dut.inflight !== 4'd3) begin bad++; $display("FAIL b2b_inflight got=%0d want=3", dut.inflight); end
            total++; if (wb_valid !== 1'b1 || {wb_tag, wb_data} !== q[0]) begin bad++; $display("FAIL b2b_data got=%0b/%0h/%0h want=%0h", wb_valid, wb_tag, wb_data, q[0]); end
        end
        idle();
        tick();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b want=0", wb_valid); end
        wb_ready = 0;
    endtask

    task automatic test_random();
        int cyc = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit drain = i >= 500;
            total++; if (issue_ok !== ((q.size() + m_infl) < DEPTH)) begin bad++; $display("FAIL rnd_ok cyc=%0d got=%0b want=%0b", cyc, issue_ok, (q.size() + m_infl) < DEPTH); end
            total++; if (wb_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", cyc, wb_valid, q.size() != 0); end
            if (q.size() != 0) begin
                total++; if ({wb_tag, wb_data} !== q[0]) begin bad++; $display("FAIL rnd_head cyc=%0d got=%0h/%0h want=%0h", cyc, wb_tag, wb_data, q[0]); end
            end
            issue_fire = issue_ok && !drain && ($urandom_range(0, 1) == 1);
            if (issue_fire) pend.push_back('{cyc + LAT, 5'($urandom), {$urandom, $urandom}});
            res_valid = pend.size() != 0 && pend[0].due == cyc;
            if (res_valid) begin
                res_tag = pend[0].t; res_data = pend[0].d;
                void'(pend.pop_front());
            end
            wb_ready = drain || ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        idle();
        total++; if (q.size() != 0 || pend.size() != 0 || wb_valid !== 1'b0) begin bad++; $display("FAIL rnd_drain got=%0b want=0 left=%0d/%0d", wb_valid, q.size(), pend.size()); end
`ifdef WB_COLLECT_ERR_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rnd_err got=%0b want=0", err); end
`endif
    endtask

    initial begin
        idle();
        wb_ready = 0;
        m_infl = 0;
        m_err = 0;
        test_reset();
        test_single();
        test_fill();
        test_full_push_pop();
        test_orphan();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_collect_64.md
WB_COLLECT_64 -- requirements
Module: wb_collect_64

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning result-FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter LAT, default 7, meaning fixed latency of the upstream pipelined 64-bit execution unit, in cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port issue_fire  input  1  issuer launched one op into the execution unit this cycle.
REQ-006 SHALL have port issue_ok  output  1  issuer may launch an op this cycle (credit available).
REQ-007 SHALL have port res_valid  input  1  execution-unit result present this cycle.
REQ-008 SHALL have port res_tag  input  5  destination register of the result.
REQ-009 SHALL have port res_data  input  64  result value.
REQ-010 SHALL have port wb_valid  output  1  writeback entry presented.
REQ-011 SHALL have port wb_ready  input  1  register file accepts the entry this cycle.
REQ-012 SHALL have port wb_tag  output  5  destination register of the presented entry.
REQ-013 SHALL have port wb_data  output  64  value of the presented entry.

Function
REQ-014 SHALL keep inflight (0..DEPTH): +1 on issue_fire, -1 on res_valid, unchanged when both occur in the same cycle.
REQ-015 SHALL drive issue_ok combinationally = (count + inflight) < DEPTH, where count = FIFO occupancy.
REQ-016 SHALL push {res_tag,res_data} into the FIFO on res_valid when not full; the pushed entry appears on wb_* no earlier than the next cycle.
REQ-017 SHALL pop the head when wb_valid && wb_ready; wb_valid = (count != 0); wb_tag/wb_data show the head and hold stable while wb_valid && !wb_ready.
REQ-018 SHALL accept a push and a pop in the same cycle, leaving count unchanged, including when the FIFO is full.
REQ-019 SHALL drop a push arriving while full with no simultaneous pop (illegal; unreachable under the credit rule).
REQ-020 SHALL saturate inflight at 0 on res_valid with inflight==0 and no issue_fire, and at DEPTH on issue_fire with inflight==DEPTH (both illegal).
REQ-021 SHALL use read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-022 SHALL preserve arrival order; results are written back strictly FIFO.

Reset
REQ-023 SHALL on rst clear count, pointers and inflight; wb_valid=0, wb_tag=0, wb_data=0, issue_ok=1 in the cycle after reset is sampled.
REQ-024 SHALL give rst priority over issue_fire, res_valid and wb_ready in the same cycle; data still in the execution unit during rst is discarded by the upstream unit's own reset.

Configuration
REQ-025 SHALL, with WB_COLLECT_ERR_EN defined, add output err (1 bit): sticky, set the cycle after any illegal event in REQ-019/REQ-020, cleared only by rst.
REQ-026 SHALL, without WB_COLLECT_ERR_EN, have no err port and no error logic; all other behaviour is identical.

Structure
REQ-027 SHALL take TAG_W=5, DATA_W=64 and the default DEPTH/LAT from the shared core package.
REQ-028 SHALL contain one sub-module, wb_fifo (storage, pointers, count), instantiated once; credit and inflight logic stay in wb_collect_64.

Verification
REQ-029 SHALL check: after reset, issue 1 op with tag 3, result 64'hEEEEEEEEEEEEEEEE arriving LAT cycles later, wb_ready=1 -> wb_valid one cycle after res_valid, tag 3, data matches, issue_ok stays 1.
REQ-030 SHALL check: wb_ready=0, issue_fire every cycle while issue_ok -> exactly 8 issues accepted, then issue_ok=0; after 8 results, count=8; raise wb_ready -> tags drain in issue order, issue_ok returns 1 the cycle after the first pop.
REQ-031 SHALL check: FIFO full, wb_ready=1 -> push and pop in the same cycle leave count=8 with no loss (directed by forcing a full state with stalled writeback).
REQ-032 SHALL check: res_valid with inflight=0 -> no inflight change, no pop disturbance; err=1 next cycle when WB_COLLECT_ERR_EN is defined.
REQ-033 SHALL check: rst asserted with count=5, inflight=3 -> next cycle wb_valid=0, issue_ok=1, err=0.
REQ-034 SHALL check: issue_fire and res_valid in the same cycle for 20 cycles with wb_ready=1 -> inflight constant, data on wb_data is bit-exact and in order.
